// File: rtl/link_sync_pkg.sv
// link_sync shared types: FSM state and word-class encodings.
// Imported by the lane synchroniser and its helpers.
package link_sync_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ACQ   = 2'd1,
    SYNC  = 2'd2,
    CHECK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    W_BAD   = 2'd0,
    W_COMMA = 2'd1,
    W_DATA  = 2'd2
  } wclass_t;

endpackage

// File: rtl/link_sync_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Clear and increment together load 1.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] MAX = '1;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? WIDTH'(1) : '0;
    end else if (inc && cnt != MAX) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/link_sync.sv
// Lane sync stage: hysteresis FSM over comma words,
// payload forwarding and saturating error count.
module link_sync
  import link_sync_pkg::*;
#(
  parameter int BYTES   = 4,
  parameter int ACQUIRE = 4,
  parameter int LOSE    = 4,
  parameter int RECOVER = 2,
  parameter int ERRW    = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [BYTES-1:0]   pattern_i,
  input  logic [BYTES-1:0]   comma_i,
  input  logic [BYTES*8-1:0] data_i,
  input  logic [BYTES-1:0]   err_i,
  input  logic               clear_i,
  output logic [BYTES*8-1:0] data_o,
  output logic               valid_o,
  output logic               synced_o,
  output logic [ERRW-1:0]    err_cnt_o
);

  localparam int AW = $clog2(ACQUIRE) + 1;
  localparam int LW = $clog2(LOSE) + 1;
  localparam int RW = $clog2(RECOVER) + 1;

  localparam logic [AW-1:0] ACQ_T = AW'(ACQUIRE);
  localparam logic [LW-1:0] LOSE_T = LW'(LOSE);
  localparam logic [RW-1:0] REC_T = RW'(RECOVER);

  state_t        state;
  wclass_t       wc;
  logic [AW-1:0] acq_cnt, acq_inc;
  logic [LW-1:0] bad_cnt, bad_inc;
  logic [RW-1:0] good_cnt, good_inc;
  logic          in_sync;

  always_comb begin
    wc = W_DATA;
    if (err_i != '0 || (comma_i != '0 && comma_i != pattern_i))
      wc = W_BAD;
    else if (comma_i == pattern_i)
      wc = W_COMMA;
  end

  assign in_sync  = (state == SYNC) || (state == CHECK);
  assign acq_inc  = acq_cnt + AW'(1);
  assign bad_inc  = bad_cnt + LW'(1);
  assign good_inc = good_cnt + RW'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= HUNT;
      acq_cnt  <= '0;
      bad_cnt  <= '0;
      good_cnt <= '0;
      synced_o <= 1'b0;
      valid_o  <= 1'b0;
      data_o   <= '0;
    end else begin
      data_o  <= data_i;
      // DATA never leaves SYNC/CHECK, so current state decides
      valid_o <= (wc == W_DATA) && in_sync;
      unique case (state)
        HUNT: begin
          if (wc == W_COMMA) begin
            if (ACQUIRE == 1) begin
              state    <= SYNC;
              synced_o <= 1'b1;
            end else begin
              state   <= ACQ;
              acq_cnt <= AW'(1);
            end
          end
        end
        ACQ: begin
          if (wc == W_COMMA) begin
            if (acq_inc == ACQ_T) begin
              state    <= SYNC;
              synced_o <= 1'b1;
              acq_cnt  <= '0;
            end else begin
              acq_cnt <= acq_inc;
            end
          end else if (wc == W_BAD) begin
            state   <= HUNT;
            acq_cnt <= '0;
          end
        end
        SYNC: begin
          if (wc == W_BAD) begin
            if (LOSE == 1) begin
              state    <= HUNT;
              synced_o <= 1'b0;
            end else begin
              state    <= CHECK;
              bad_cnt  <= LW'(1);
              good_cnt <= '0;
            end
          end
        end
        CHECK: begin
          if (wc == W_BAD) begin
            good_cnt <= '0;
            if (bad_inc == LOSE_T) begin
              state    <= HUNT;
              synced_o <= 1'b0;
              bad_cnt  <= '0;
            end else begin
              bad_cnt <= bad_inc;
            end
          end else if (good_inc == REC_T) begin
            state    <= SYNC;
            bad_cnt  <= '0;
            good_cnt <= '0;
          end else begin
            good_cnt <= good_inc;
          end
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(ERRW)) u_err_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .inc    ((wc == W_BAD) && in_sync),
    .clr    (clear_i),
    .cnt    (err_cnt_o)
  );

endmodule
